// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sequencer: op codes, FSM states, error
// codes and the op decode helpers used by the control path.
package alu_pkg;

  localparam int DATA_W = 32;
  localparam int OP_W   = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [OP_W-1:0] OP_ADD  = 5'd3;
  localparam logic [OP_W-1:0] OP_SUB  = 5'd4;
  localparam logic [OP_W-1:0] OP_AND  = 5'd5;
  localparam logic [OP_W-1:0] OP_OR   = 5'd6;
  localparam logic [OP_W-1:0] OP_ROR  = 5'd7;
  localparam logic [OP_W-1:0] OP_ROL  = 5'd8;
  localparam logic [OP_W-1:0] OP_SHR  = 5'd9;
  localparam logic [OP_W-1:0] OP_SHRA = 5'd10;
  localparam logic [OP_W-1:0] OP_SHL  = 5'd11;
  localparam logic [OP_W-1:0] OP_ADDI = 5'd12;
  localparam logic [OP_W-1:0] OP_ANDI = 5'd13;
  localparam logic [OP_W-1:0] OP_ORI  = 5'd14;
  localparam logic [OP_W-1:0] OP_DIV  = 5'd15;
  localparam logic [OP_W-1:0] OP_MUL  = 5'd16;
  localparam logic [OP_W-1:0] OP_NEG  = 5'd17;
  localparam logic [OP_W-1:0] OP_NOT  = 5'd18;
  localparam logic [OP_W-1:0] OP_SHLA = 5'd19;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_DIV0    = 2'b10;

  // Legal op codes form one contiguous range, ADD through SHLA.
  function automatic logic op_legal(input logic [OP_W-1:0] op);
    return (op >= OP_ADD) && (op <= OP_SHLA);
  endfunction

  // Number of EXEC cycles an op occupies before its result is captured.
  function automatic int unsigned op_latency(input logic [OP_W-1:0] op,
                                             input int unsigned mul_cycles,
                                             input int unsigned div_cycles);
    case (op)
      OP_MUL:  return mul_cycles;
      OP_DIV:  return div_cycles;
      default: return 1;
    endcase
  endfunction

endpackage

// File: rtl/alu_sequencer.sv
// Request/response sequencer in front of an external multi-cycle ALU.
// Accepts one op at a time, presents its operands to the ALU for the op's
// latency, captures the result and holds it until the consumer takes it.
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 8
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [OP_W-1:0]   req_op,
  input  logic [DATA_W-1:0] req_ra,
  input  logic [DATA_W-1:0] req_rb,
  input  logic              flush,
  output logic [DATA_W-1:0] alu_ra,
  output logic [DATA_W-1:0] alu_rb,
  output logic [OP_W-1:0]   alu_op,
  input  logic [DATA_W-1:0] alu_hi,
  input  logic [DATA_W-1:0] alu_lo,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_hi,
  output logic [DATA_W-1:0] rsp_lo,
  output logic [1:0]        rsp_err,
  output logic              busy
);

  localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [OP_W-1:0]     op_q, op_d;
  logic [DATA_W-1:0]   ra_q, ra_d;
  logic [DATA_W-1:0]   rb_q, rb_d;
  logic [DATA_W-1:0]   hi_q, hi_d;
  logic [DATA_W-1:0]   lo_q, lo_d;
  logic [1:0]          err_q, err_d;
  logic                accept;
  logic                div_zero;
  logic [31:0]         lat;

  assign req_ready = (state_q == ST_IDLE) && clear;
  assign accept    = req_valid && req_ready;
  assign div_zero  = (req_op == OP_DIV) && (req_rb == '0);
  assign lat       = op_latency(req_op, MUL_CYCLES, DIV_CYCLES);

  assign alu_ra    = ra_q;
  assign alu_rb    = rb_q;
  assign alu_op    = (state_q == ST_EXEC) ? op_q : '0;
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_hi    = hi_q;
  assign rsp_lo    = lo_q;
  assign rsp_err   = err_q;
  assign busy      = (state_q != ST_IDLE);

  // Next-state and datapath-load decisions; flush outranks completion and handshake.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (!op_legal(req_op)) begin
            state_d = ST_RESP;
            hi_d    = '0;
            lo_d    = '0;
            err_d   = ERR_ILLEGAL;
          end else if (div_zero) begin
            state_d = ST_RESP;
            hi_d    = '0;
            lo_d    = '0;
            err_d   = ERR_DIV0;
          end else begin
            state_d = ST_EXEC;
            cnt_d   = CNT_W'(lat - 32'd1);
            op_d    = req_op;
            ra_d    = req_ra;
            rb_d    = req_rb;
          end
        end
      end
      ST_EXEC: begin
        if (flush) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = ST_RESP;
          hi_d    = alu_hi;
          lo_d    = alu_lo;
          err_d   = ERR_NONE;
        end else begin
          cnt_d   = cnt_q - 1'b1;
        end
      end
      ST_RESP: begin
        if (flush || rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State, counter, operand and response registers; clear abandons everything at once.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      ra_q    <= '0;
      rb_q    <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      err_q   <= err_d;
    end
  end

endmodule
